load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter WATCHDOG, default 16, max cycles in a request state before abort.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  core presents a load/store.
REQ-005 req_ready  output  1  unit idle, accepts request.
REQ-006 req_store  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RISC-V funct3 of the access.
REQ-008 req_addr  input  20  byte address.
REQ-009 req_wdata  input  64  store data, right-aligned.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  64  extended load result, 0 for stores.
REQ-012 resp_error  output  1  illegal funct3 or watchdog abort, valid with resp_valid.
REQ-013 mc_operation  output  3  controller opcode: NOP 000, READ_D 001, READ_W 010, READ_H 011, READ_B 100, WRITE 111.
REQ-014 mc_address  output  20  controller base address.
REQ-015 mc_write_data  output  64  controller write data.
REQ-016 mc_status  input  1  controller busy, 1 = wait.
REQ-017 mc_data  input  64  controller read data, byte k = mem[address+k].

Function
REQ-018 States IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; accept on req_valid && req_ready, latching store, funct3, addr, wdata.
REQ-020 Load map: 000 LB->READ_B sign, 001 LH->READ_H sign, 010 LW->READ_W sign, 011 LD->READ_D, 100 LBU->READ_B zero, 101 LHU->READ_H zero, 110 LWU->READ_W zero, 111 illegal.
REQ-021 Store map: 011 SD->WRITE only; 000 SB, 001 SH, 010 SW->read-modify-write; 100-111 illegal.
REQ-022 Illegal funct3: IDLE->RESP directly, resp_error=1, no controller operation issued.
REQ-023 Loads and RMW stores enter RD_REQ; SD enters WR_REQ.
REQ-024 *_REQ drives the opcode until mc_status=1, then moves to *_WAIT; *_WAIT drives NOP and exits when mc_status=0.
REQ-025 RD_WAIT exit: load -> capture extended mc_data, go RESP; RMW store -> capture merged word, go WR_REQ.
REQ-026 RMW merge: low 1/2/4 bytes of req_wdata replace bytes 0..n-1 of mc_data; remaining bytes kept.
REQ-027 WR_REQ drives mc_write_data from merged word (RMW) or req_wdata (SD); WR_WAIT exit -> RESP.
REQ-028 Extension uses only the low 1/2/4/8 bytes of mc_data; stale upper bytes SHALL never reach resp_rdata.
REQ-029 mc_address = latched req_addr in every non-IDLE state; 20-bit wrap is the controller's concern, unchanged here.
REQ-030 mc_operation SHALL be NOP in IDLE, *_WAIT and RESP.
REQ-031 Watchdog counter clears on entering *_REQ; if mc_status stays 0 for WATCHDOG cycles, go RESP with resp_error=1, mc_operation NOP.
REQ-032 RESP lasts exactly one cycle, asserts resp_valid, returns to IDLE; a new request is accepted no earlier than the following cycle.
REQ-033 Request inputs outside IDLE SHALL be ignored.

Reset
REQ-034 reset_n low: state IDLE, req_ready 1, resp_valid 0, resp_error 0, resp_rdata 0, mc_operation NOP, mc_address 0, mc_write_data 0, watchdog 0, immediately and asynchronously.
REQ-035 Reset mid-operation abandons the access without a response; the controller sees NOP from the reset edge on.

Structure
REQ-036 Opcode constants, state encoding and funct3 constants SHALL live in shared package lsu_pkg.
REQ-037 Extension and merge SHALL be one combinational sub-module lsu_extend (inputs funct3, mc_data, wdata; outputs load value, merged word).

Verification
REQ-038 LB at 0x00010, mc_data byte0=0x80 -> READ_B issued, resp_rdata=0xFFFF_FFFF_FFFF_FF80, error 0.
REQ-039 LWU at 0x00020, mc_data=0xAAAA_AAAA_8765_4321 -> READ_W issued, resp_rdata=0x0000_0000_8765_4321.
REQ-040 SH at 0x00030, wdata=0xBEEF, old=0x1122_3344_5566_7788 -> READ_D then WRITE with 0x1122_3344_5566_BEEF.
REQ-041 SD at 0x00040 -> single WRITE with req_wdata; no READ issued; resp_valid one pulse.
REQ-042 Load funct3 111 -> resp_valid next cycle with resp_error=1, mc_operation stays NOP.
REQ-043 mc_status held 0 for 16 cycles in RD_REQ -> resp_error=1; reset_n low in RD_WAIT -> IDLE, NOP, no resp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared definitions for the load/store unit. Holds the FSM
//               state encoding, the memory-controller opcodes, the RISC-V
//               funct3 codes and small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_WAIT = 3'd4,
        S_RESP    = 3'd5
    } lsu_state_t;

    // Memory-controller opcodes
    localparam logic [2:0] c_MC_NOP    = 3'b000;
    localparam logic [2:0] c_MC_READ_D = 3'b001;
    localparam logic [2:0] c_MC_READ_W = 3'b010;
    localparam logic [2:0] c_MC_READ_H = 3'b011;
    localparam logic [2:0] c_MC_READ_B = 3'b100;
    localparam logic [2:0] c_MC_WRITE  = 3'b111;

    // funct3 codes (loads; stores share the 000..011 size encoding)
    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_D  = 3'b011;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;
    localparam logic [2:0] c_F3_WU = 3'b110;

    // Loads reject only 111; stores reject every unsigned-style code.
    function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
        return store ? f3[2] : (f3 == 3'b111);
    endfunction

    // Read opcode for the first phase. RMW stores always fetch the full
    // doubleword so the merge can preserve the untouched bytes.
    function automatic logic [2:0] read_op(input logic store, input logic [2:0] f3);
        logic [2:0] op;
        if (store) begin
            op = c_MC_READ_D;
        end else begin
            case (f3[1:0])
                2'b00:   op = c_MC_READ_B;
                2'b01:   op = c_MC_READ_H;
                2'b10:   op = c_MC_READ_W;
                default: op = c_MC_READ_D;
            endcase
        end
        return op;
    endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_extend.sv
`default_nettype none
// ============================================================================
// Module      : lsu_extend
// Description : Combinational load extension and store merge.
//   i_funct3   : access funct3
//   i_mc_data  : controller read data (byte k = mem[address+k])
//   i_wdata    : right-aligned store data
//   o_load_val : sign/zero-extended load result from the low bytes only
//   o_merged   : i_mc_data with its low 1/2/4 bytes replaced by i_wdata
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [63:0] i_mc_data,
    input  logic [63:0] i_wdata,
    output logic [63:0] o_load_val,
    output logic [63:0] o_merged
);

    always_comb begin
        o_load_val = i_mc_data;
        case (i_funct3)
            c_F3_B:  o_load_val = {{56{i_mc_data[7]}},  i_mc_data[7:0]};
            c_F3_H:  o_load_val = {{48{i_mc_data[15]}}, i_mc_data[15:0]};
            c_F3_W:  o_load_val = {{32{i_mc_data[31]}}, i_mc_data[31:0]};
            c_F3_BU: o_load_val = {56'd0, i_mc_data[7:0]};
            c_F3_HU: o_load_val = {48'd0, i_mc_data[15:0]};
            c_F3_WU: o_load_val = {32'd0, i_mc_data[31:0]};
            default: o_load_val = i_mc_data;
        endcase
    end

    always_comb begin
        o_merged = i_wdata;
        case (i_funct3[1:0])
            2'b00:   o_merged = {i_mc_data[63:8],  i_wdata[7:0]};
            2'b01:   o_merged = {i_mc_data[63:16], i_wdata[15:0]};
            2'b10:   o_merged = {i_mc_data[63:32], i_wdata[31:0]};
            default: o_merged = i_wdata;
        endcase
    end

endmodule : lsu_extend
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store unit bridging a core request
//               port to a simple memory controller. Sub-doubleword stores are
//               done as read-modify-write; a watchdog aborts request phases
//               the controller never acknowledges.
//   Core side   : req_valid/req_ready/req_store/req_funct3/req_addr/req_wdata,
//                 resp_valid/resp_rdata/resp_error
//   Controller  : mc_operation/mc_address/mc_write_data, mc_status/mc_data
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WATCHDOG = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [19:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_error,
    output logic [2:0]  mc_operation,
    output logic [19:0] mc_address,
    output logic [63:0] mc_write_data,
    input  logic        mc_status,
    input  logic [63:0] mc_data
);

    localparam int                c_WD_W    = $clog2(WATCHDOG + 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(WATCHDOG - 1);

    lsu_state_t        r_state;
    lsu_state_t        w_next_state;
    logic              r_store;
    logic [2:0]        r_funct3;
    logic [19:0]       r_addr;
    logic [63:0]       r_wdata;
    logic [63:0]       r_wword;   // word sent with WRITE (merged or SD data)
    logic [63:0]       r_rdata;
    logic              r_error;
    logic [c_WD_W-1:0] r_wd;

    logic              w_accept;
    logic              w_illegal;
    logic              w_in_req;
    logic              w_wd_expired;
    logic [63:0]       w_load_val;
    logic [63:0]       w_merged;

    assign w_accept     = (r_state == S_IDLE) && req_valid;
    assign w_illegal    = f3_illegal(req_store, req_funct3);
    assign w_in_req     = (r_state == S_RD_REQ) || (r_state == S_WR_REQ);
    assign w_wd_expired = w_in_req && !mc_status && (r_wd == c_WD_LAST);

    lsu_extend u_extend (
        .i_funct3   (r_funct3),
        .i_mc_data  (mc_data),
        .i_wdata    (r_wdata),
        .o_load_val (w_load_val),
        .o_merged   (w_merged)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_illegal)
                        w_next_state = S_RESP;
                    else if (req_store && (req_funct3 == c_F3_D))
                        w_next_state = S_WR_REQ;
                    else
                        w_next_state = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                if (mc_status)
                    w_next_state = S_RD_WAIT;
                else if (w_wd_expired)
                    w_next_state = S_RESP;
            end
            S_RD_WAIT: begin
                if (!mc_status)
                    w_next_state = r_store ? S_WR_REQ : S_RESP;
            end
            S_WR_REQ: begin
                if (mc_status)
                    w_next_state = S_WR_WAIT;
                else if (w_wd_expired)
                    w_next_state = S_RESP;
            end
            S_WR_WAIT: begin
                if (!mc_status)
                    w_next_state = S_RESP;
            end
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_store  <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 20'd0;
            r_wdata  <= 64'd0;
            r_wword  <= 64'd0;
            r_rdata  <= 64'd0;
            r_error  <= 1'b0;
            r_wd     <= '0;
        end else begin
            if (w_accept) begin
                r_store  <= req_store;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_wword  <= req_wdata;
                r_rdata  <= 64'd0;
                r_error  <= w_illegal;
            end

            if (r_state == S_RD_WAIT && !mc_status) begin
                if (r_store)
                    r_wword <= w_merged;
                else
                    r_rdata <= w_load_val;
            end

            if (w_wd_expired)
                r_error <= 1'b1;

            // Counts only while a request phase is unacknowledged, so it is
            // always zero on entry to either request state.
            if (w_in_req && !mc_status && !w_wd_expired)
                r_wd <= r_wd + 1'b1;
            else
                r_wd <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        req_ready     = (r_state == S_IDLE);
        resp_valid    = (r_state == S_RESP);
        resp_error    = (r_state == S_RESP) && r_error;
        resp_rdata    = r_rdata;
        mc_operation  = c_MC_NOP;
        mc_address    = (r_state == S_IDLE) ? 20'd0 : r_addr;
        mc_write_data = 64'd0;
        case (r_state)
            S_RD_REQ:  mc_operation = read_op(r_store, r_funct3);
            S_WR_REQ: begin
                mc_operation  = c_MC_WRITE;
                mc_write_data = r_wword;
            end
            S_WR_WAIT: mc_write_data = r_wword;
            default:   mc_operation = c_MC_NOP;
        endcase
    end

endmodule : load_store_unit
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit. The bench
//               plays the memory controller by hand from its tasks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam logic [2:0] c_NOP    = 3'b000;
    localparam logic [2:0] c_READ_D = 3'b001;
    localparam logic [2:0] c_READ_W = 3'b010;
    localparam logic [2:0] c_READ_H = 3'b011;
    localparam logic [2:0] c_READ_B = 3'b100;
    localparam logic [2:0] c_WRITE  = 3'b111;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [19:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_error;
    logic [2:0]  mc_operation;
    logic [19:0] mc_address;
    logic [63:0] mc_write_data;
    logic        mc_status;
    logic [63:0] mc_data;

    int n_pass;
    int n_total;

    load_store_unit #(.WATCHDOG(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_store     (req_store),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_error    (resp_error),
        .mc_operation  (mc_operation),
        .mc_address    (mc_address),
        .mc_write_data (mc_write_data),
        .mc_status     (mc_status),
        .mc_data       (mc_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request for a single cycle; returns on the following
    // negedge, when the unit has left IDLE.
    task automatic do_issue(input logic st, input logic [2:0] f3,
                            input logic [19:0] a, input logic [63:0] wd);
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    // Wait for a controller opcode, record it, then acknowledge:
    // one busy cycle followed by a done cycle carrying data.
    task automatic ctrl_service(input logic [63:0] data, output logic [2:0] op,
                                output logic [19:0] a, output logic [63:0] wd,
                                output bit seen);
        seen = 1'b0;
        op   = c_NOP;
        a    = '0;
        wd   = '0;
        for (int i = 0; i < 32; i++) begin
            if (mc_operation !== c_NOP) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (seen) begin
            op        = mc_operation;
            a         = mc_address;
            wd        = mc_write_data;
            mc_status = 1'b1;
            mc_data   = data;
            @(negedge clk);
            mc_status = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic wait_resp(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (resp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        n_total++; if (req_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", req_ready); else n_pass++;
        n_total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); else n_pass++;
        n_total++; if (resp_error !== 1'b0) $display("FAIL reset_resp_error got=%b exp=0", resp_error); else n_pass++;
        n_total++; if (resp_rdata !== 64'd0) $display("FAIL reset_rdata got=%h exp=0", resp_rdata); else n_pass++;
        n_total++; if (mc_operation !== c_NOP) $display("FAIL reset_mc_op got=%b exp=000", mc_operation); else n_pass++;
        n_total++; if (mc_address !== 20'd0) $display("FAIL reset_mc_addr got=%h exp=0", mc_address); else n_pass++;
        n_total++; if (mc_write_data !== 64'd0) $display("FAIL reset_mc_wdata got=%h exp=0", mc_write_data); else n_pass++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_loads();
        logic [2:0]  f3_t  [7];
        logic [63:0] dat_t [7];
        logic [2:0]  op_t  [7];
        logic [63:0] exp_t [7];
        logic [2:0]  op;
        logic [19:0] a;
        logic [19:0] exp_a;
        logic [63:0] wd;
        bit          seen;
        f3_t  = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
        dat_t = '{64'h1234_5678_9ABC_DE80, 64'hFFFF_FFFF_FFFF_7FFE, 64'h0000_0000_8000_0001,
                  64'hDEAD_BEEF_0123_4567, 64'hFFFF_FFFF_FFFF_FFF0, 64'h1111_1111_1111_8001,
                  64'hAAAA_AAAA_8765_4321};
        op_t  = '{c_READ_B, c_READ_H, c_READ_W, c_READ_D, c_READ_B, c_READ_H, c_READ_W};
        exp_t = '{64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_7FFE, 64'hFFFF_FFFF_8000_0001,
                  64'hDEAD_BEEF_0123_4567, 64'h0000_0000_0000_00F0, 64'h0000_0000_0000_8001,
                  64'h0000_0000_8765_4321};
        for (int i = 0; i < 7; i++) begin
            exp_a = 20'h00010 + 20'(i * 16);
            do_issue(1'b0, f3_t[i], exp_a, 64'hFFFF_FFFF_FFFF_FFFF);
            ctrl_service(dat_t[i], op, a, wd, seen);
            n_total++; if (!seen || op !== op_t[i]) $display("FAIL load%0d_op got=%b exp=%b seen=%0d", i, op, op_t[i], seen); else n_pass++;
            n_total++; if (a !== exp_a) $display("FAIL load%0d_addr got=%h exp=%h", i, a, exp_a); else n_pass++;
            wait_resp(seen);
            n_total++; if (!seen || resp_rdata !== exp_t[i]) $display("FAIL load%0d_rdata got=%h exp=%h seen=%0d", i, resp_rdata, exp_t[i], seen); else n_pass++;
            n_total++; if (resp_error !== 1'b0) $display("FAIL load%0d_error got=%b exp=0", i, resp_error); else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_rmw_stores();
        logic [2:0]  f3_t [3];
        logic [63:0] wd_t [3];
        logic [63:0] exp_t [3];
        logic [2:0]  op;
        logic [19:0] a;
        logic [63:0] wd;
        bit          seen;
        f3_t  = '{3'b000, 3'b001, 3'b010};
        wd_t  = '{64'hFFFF_FFFF_FFFF_FFAB, 64'hFFFF_FFFF_FFFF_BEEF, 64'h5555_5555_CAFE_BABE};
        exp_t = '{64'h1122_3344_5566_77AB, 64'h1122_3344_5566_BEEF, 64'h1122_3344_CAFE_BABE};
        for (int i = 0; i < 3; i++) begin
            do_issue(1'b1, f3_t[i], 20'h00030, wd_t[i]);
            ctrl_service(64'h1122_3344_5566_7788, op, a, wd, seen);
            n_total++; if (!seen || op !== c_READ_D || a !== 20'h00030) $display("FAIL rmw%0d_read got_op=%b got_addr=%h exp_op=001 exp_addr=00030", i, op, a); else n_pass++;
            ctrl_service(64'h0, op, a, wd, seen);
            n_total++; if (!seen || op !== c_WRITE) $display("FAIL rmw%0d_write_op got=%b exp=111 seen=%0d", i, op, seen); else n_pass++;
            n_total++; if (wd !== exp_t[i]) $display("FAIL rmw%0d_wdata got=%h exp=%h", i, wd, exp_t[i]); else n_pass++;
            wait_resp(seen);
            n_total++; if (!seen || resp_error !== 1'b0 || resp_rdata !== 64'd0) $display("FAIL rmw%0d_resp got_err=%b got_rdata=%h exp_err=0 exp_rdata=0", i, resp_error, resp_rdata); else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_sd();
        logic [2:0]  op;
        logic [19:0] a;
        logic [63:0] wd;
        bit          seen;
        do_issue(1'b1, 3'b011, 20'h00040, 64'h0123_4567_89AB_CDEF);
        n_total++; if (req_ready !== 1'b0) $display("FAIL sd_ready_busy got=%b exp=0", req_ready); else n_pass++;
        // A competing request while busy must be ignored.
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 20'h00999;
        req_valid  = 1'b1;
        ctrl_service(64'hFFFF_FFFF_FFFF_FFFF, op, a, wd, seen);
        req_valid  = 1'b0;
        n_total++; if (!seen || op !== c_WRITE) $display("FAIL sd_first_op got=%b exp=111 seen=%0d", op, seen); else n_pass++;
        n_total++; if (a !== 20'h00040) $display("FAIL sd_addr got=%h exp=00040", a); else n_pass++;
        n_total++; if (wd !== 64'h0123_4567_89AB_CDEF) $display("FAIL sd_wdata got=%h exp=0123456789abcdef", wd); else n_pass++;
        wait_resp(seen);
        n_total++; if (!seen || resp_error !== 1'b0) $display("FAIL sd_resp got_err=%b seen=%0d exp_err=0", resp_error, seen); else n_pass++;
        @(negedge clk);
        n_total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL sd_pulse got_valid=%b got_ready=%b exp_valid=0 exp_ready=1", resp_valid, req_ready); else n_pass++;
    endtask

    task automatic test_illegal();
        logic        st_t [2];
        logic [2:0]  f3_t [2];
        st_t = '{1'b0, 1'b1};
        f3_t = '{3'b111, 3'b101};
        for (int i = 0; i < 2; i++) begin
            do_issue(st_t[i], f3_t[i], 20'h00050, 64'h1234);
            n_total++; if (resp_valid !== 1'b1 || resp_error !== 1'b1) $display("FAIL illegal%0d_resp got_valid=%b got_err=%b exp=1/1", i, resp_valid, resp_error); else n_pass++;
            n_total++; if (mc_operation !== c_NOP) $display("FAIL illegal%0d_op got=%b exp=000", i, mc_operation); else n_pass++;
            @(negedge clk);
            n_total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL illegal%0d_after got_valid=%b got_ready=%b exp=0/1", i, resp_valid, req_ready); else n_pass++;
        end
    endtask

    task automatic test_watchdog();
        int n;
        bit op_ok;
        bit seen;
        n     = 0;
        op_ok = 1'b1;
        seen  = 1'b0;
        do_issue(1'b0, 3'b000, 20'h00060, 64'h0);
        for (int i = 0; i < 40; i++) begin
            if (resp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (mc_operation !== c_READ_B) op_ok = 1'b0;
            n++;
            @(negedge clk);
        end
        n_total++; if (!seen || n != 16) $display("FAIL wd_cycles got=%0d exp=16 seen=%0d", n, seen); else n_pass++;
        n_total++; if (!op_ok) $display("FAIL wd_op_held got=0 exp=1"); else n_pass++;
        n_total++; if (resp_error !== 1'b1 || mc_operation !== c_NOP) $display("FAIL wd_abort got_err=%b got_op=%b exp=1/000", resp_error, mc_operation); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int hits;
        hits = 0;
        do_issue(1'b0, 3'b010, 20'h00070, 64'h0);
        mc_status = 1'b1;
        mc_data   = 64'h0;
        @(negedge clk);
        n_total++; if (mc_operation !== c_NOP) $display("FAIL rdwait_op got=%b exp=000", mc_operation); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_total++; if (mc_operation !== c_NOP || mc_address !== 20'd0) $display("FAIL mid_reset_mc got_op=%b got_addr=%h exp=000/0", mc_operation, mc_address); else n_pass++;
        n_total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) $display("FAIL mid_reset_idle got_ready=%b got_valid=%b exp=1/0", req_ready, resp_valid); else n_pass++;
        mc_status = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) hits++;
        end
        n_total++; if (hits != 0 || req_ready !== 1'b1) $display("FAIL mid_reset_no_resp got_pulses=%0d got_ready=%b exp=0/1", hits, req_ready); else n_pass++;
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        reset_n    = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 20'd0;
        req_wdata  = 64'd0;
        mc_status  = 1'b0;
        mc_data    = 64'd0;
        test_reset();
        test_loads();
        test_rmw_stores();
        test_sd();
        test_illegal();
        test_watchdog();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_load_store_unit
`default_nettype wire
